// File: rtl/count_strip_cw16.sv
// count_strip_cw16: checks an annotated 0..cnt_limit count stream, strips the count and rebuilds tlast.
// Define COUNT_STRIP_STATS_EN to build the err_cnt / frame_cnt statistics registers.
module count_strip_cw16 #(
  parameter int DATA_WIDTH  = 32,
  parameter int TUSER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  input  logic [15:0]            cnt_limit,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [15:0]            s_axis_count,
  input  logic                   s_axis_final_cnt,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   locked,
  output logic                   seq_err,
  output logic [15:0]            err_cnt,
  output logic [31:0]            frame_cnt
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam int         FIFO_DEPTH = 4;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic [15:0] r_exp;
  logic [15:0] w_exp_next;
  logic        r_seq_err;

  logic        w_accept;
  logic        w_fwd;
  logic        w_bad;
  logic        w_cnt_zero;
  logic        w_cnt_at_limit;
  logic        w_cnt_match;

  logic                   r_s1_valid;
  logic [DATA_WIDTH-1:0]  r_s1_data;
  logic [TUSER_WIDTH-1:0] r_s1_user;
  logic                   r_s1_last;

  logic [DATA_WIDTH-1:0]  r_fifo_data [FIFO_DEPTH];
  logic [TUSER_WIDTH-1:0] r_fifo_user [FIFO_DEPTH];
  logic                   r_fifo_last [FIFO_DEPTH];
  logic [1:0]             r_wr_ptr;
  logic [1:0]             r_rd_ptr;
  logic [2:0]             r_occ;
  logic                   w_push;
  logic                   w_pop;

  // Ready looks only at registered occupancy: one beat may sit in S1 and one more be accepted
  // after ready falls, so at most three entries are ever in use.
  assign s_axis_tready  = (r_occ <= 3'd1);
  assign w_accept       = s_axis_tvalid & s_axis_tready & ~sync_reset;
  assign w_cnt_zero     = (s_axis_count == 16'd0);
  assign w_cnt_at_limit = (s_axis_count == cnt_limit);
  assign w_cnt_match    = (s_axis_count == r_exp);

  always_comb begin
    w_state_next = r_state;
    w_exp_next   = r_exp;
    w_fwd        = 1'b0;
    w_bad        = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_HUNT: begin
          // A zero count takes priority over the final-count resync path.
          if (w_cnt_zero) begin
            w_fwd        = 1'b1;
            w_state_next = ST_LOCKED;
            w_exp_next   = s_axis_final_cnt ? 16'd0 : 16'd1;
          end else if (s_axis_final_cnt && w_cnt_at_limit) begin
            w_state_next = ST_LOCKED;
            w_exp_next   = 16'd0;
          end
        end
        default: begin
          if (w_cnt_match && (s_axis_final_cnt == w_cnt_at_limit)) begin
            w_fwd      = 1'b1;
            w_exp_next = s_axis_final_cnt ? 16'd0 : r_exp + 16'd1;
          end else begin
            w_bad        = 1'b1;
            w_state_next = ST_HUNT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state   <= ST_HUNT;
      r_exp     <= 16'd0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_exp     <= w_exp_next;
      r_seq_err <= w_bad;
    end
  end

  assign locked  = (r_state == ST_LOCKED);
  assign seq_err = r_seq_err;

  // S1 payload is captured on every accept; only r_s1_valid marks it as a forwarded beat.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_fwd;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_data <= s_axis_tdata;
      r_s1_user <= s_axis_tuser;
      r_s1_last <= s_axis_final_cnt;
    end
  end

  assign w_push = r_s1_valid;
  assign w_pop  = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= r_s1_data;
      r_fifo_user[r_wr_ptr] <= r_s1_user;
      r_fifo_last[r_wr_ptr] <= r_s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_occ    <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_occ <= r_occ + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  // The head entry drives the outputs directly, so they hold while the head is not popped.
  assign m_axis_tvalid = (r_occ != 3'd0);
  assign m_axis_tdata  = r_fifo_data[r_rd_ptr];
  assign m_axis_tuser  = r_fifo_user[r_rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid & r_fifo_last[r_rd_ptr];

`ifdef COUNT_STRIP_STATS_EN
  logic [15:0] r_err_cnt;
  logic [31:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_err_cnt   <= 16'd0;
      r_frame_cnt <= 32'd0;
    end else begin
      if (w_bad && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
      if (w_push && r_s1_last) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
    end
  end

  assign err_cnt   = r_err_cnt;
  assign frame_cnt = r_frame_cnt;
`else
  assign err_cnt   = 16'd0;
  assign frame_cnt = 32'd0;
`endif

endmodule

// File: doc/count_strip_cw16.md
# count_strip_cw16

Receive-side counterpart to the stream count annotator. Consumes an AXI-Stream beat stream carrying a 16-bit sample count and a final-count flag. It checks that the count sequence runs 0..cnt_limit and wraps, strips the count, and regenerates `tlast` on final-count beats. Sits at the output of channelizer frame paths, ahead of packetizers. On a sequence error it drops beats until it resynchronises.

## Interface
- `DATA_WIDTH`, 32, payload width
- `TUSER_WIDTH`, 32, tuser width, passed through unmodified
- `clk` in 1: sole clock
- `sync_reset` in 1: synchronous, active-high reset
- `cnt_limit` in 16: last count value of a frame; static while `locked`=1
- `s_axis_tvalid` in 1 / `s_axis_tready` out 1: input handshake
- `s_axis_tdata` in DATA_WIDTH: payload
- `s_axis_count` in 16: annotated count
- `s_axis_final_cnt` in 1: annotated final-count flag
- `s_axis_tuser` in TUSER_WIDTH: sideband
- `m_axis_tvalid` out 1 / `m_axis_tready` in 1: output handshake
- `m_axis_tdata` out DATA_WIDTH; `m_axis_tuser` out TUSER_WIDTH
- `m_axis_tlast` out 1: equals forwarded beat's final-count flag
- `locked` out 1: checker in LOCKED state
- `seq_err` out 1: one-cycle pulse per detected error
- `err_cnt` out 16: saturating error count (stats build only)
- `frame_cnt` out 32: wrapping count of forwarded final beats (stats build only)

## Operation
- Accept = `s_axis_tvalid & s_axis_tready & ~sync_reset`.
- Register `exp[15:0]` holds the expected next count. FSM has two states: HUNT and LOCKED.
- HUNT (reset state), on each accepted beat:
  - `count`==0: forward the beat, go to LOCKED. `exp` = 1, or 0 if `final_cnt`.
  - `final_cnt`=1 with `count`==`cnt_limit`: drop the beat, go to LOCKED with `exp`=0.
  - Any other beat: drop.
- LOCKED, on each accepted beat:
  - Beat is good when `count`==`exp` and `final_cnt`==(`count`==`cnt_limit`).
  - Good beat: forward it. `exp` = `final_cnt` ? 0 : `exp`+1 (16-bit wrap).
  - Bad beat: drop it, pulse `seq_err`, increment `err_cnt` (saturates at 0xFFFF), go to HUNT.
- If both HUNT conditions hold on one beat (`cnt_limit`=0, count 0, final), the count==0 rule wins: forward the beat, `exp`=0.
- Forwarded beats enter a 4-entry output FIFO: {tdata, tuser, final_cnt→tlast}.
- `frame_cnt` increments when a beat with `tlast`=1 is written to the FIFO.

## Timing
- Pipeline: the accepted beat is registered in stage S1, where check and FSM update happen. The FIFO is written at the end of S1.
- Latency: a beat accepted at cycle N appears on `m_axis_tvalid` at N+2 if the FIFO was empty.
- `s_axis_tready` = (registered FIFO occupancy ≤ 1). Worst case is 1 beat in the FIFO, 1 in S1 and 1 being accepted, total 3 ≤ 4, so the FIFO never overflows. The bench asserts this.
- `seq_err` is asserted in cycle N+1 for a bad beat accepted at N.
- `locked` is registered; it changes in cycle N+1.
- Output obeys AXI-Stream rules: `m_axis_t*` hold stable while `m_axis_tvalid` & ~`m_axis_tready`.
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `locked`=0, `seq_err`=0, `err_cnt`=0, `frame_cnt`=0. State resets to HUNT, `exp`=0, FIFO empty.
- `s_axis_tready`=1 in the cycle after reset releases.
- Reset mid-frame flushes S1 and the FIFO, with no partial output.
- Dropped beats consume no FIFO slot and produce no output cycle.

## Configuration
- `COUNT_STRIP_STATS_EN` defined:
  - `err_cnt` and `frame_cnt` registers are built as described.
- Undefined:
  - The registers are removed and both outputs are tied to 0.
  - `seq_err` and all datapath behaviour are unchanged.

## Test plan
- Lock from reset: `cnt_limit`=3, counts 0,1,2,3(final),0,1. All six beats forwarded. `tlast` only on the 4th beat, `locked`=1 from the cycle after the first accept, `frame_cnt`=1.
- Mid-frame start: `cnt_limit`=3, counts 2,3(final),0,1,2,3(final). First two beats dropped. Next four forwarded with `tlast` on the last. No `seq_err`.
- Skip error: locked at `exp`=2, count 3 arrives. Beat dropped, `seq_err` pulses once, `err_cnt`=1, `locked`=0. Beats dropped until count 3 (final) arrives; the next 0 is forwarded.
- Flag mismatch: `cnt_limit`=3, count 3 with `final_cnt`=0. The beat is treated as an error and the block returns to HUNT.
- Backpressure: `m_axis_tready` held low for 20 cycles under continuous input. `s_axis_tready` drops once occupancy is 2, no beat is lost or duplicated, output order is preserved, and `m_axis_t*` stay stable while stalled.
- Reset mid-frame at count 5 (`cnt_limit`=9): outputs return to reset values. After release the block is in HUNT and the next count 0 is forwarded. Without `COUNT_STRIP_STATS_EN`, `err_cnt`=`frame_cnt`=0 throughout.
